rggen_axi4lite_slice: RTL

Registered AXI4-Lite pipeline stage placed directly downstream of the rggen AXI4-Lite bridge, between the bridge's AXI4-Lite master port and the system interconnect. Each of the five channels (AW, W, AR, B, R) passes through an independent two-entry skid buffer. This cuts every valid, ready and payload timing path across the boundary while sustaining one transfer per cycle per channel. Request-side and response-side slicing can each be disabled by parameter.

---
 rtl/rggen_axi4lite_slice_if.sv | 41 ++++
 rtl/rggen_axi4lite_slice.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rggen_axi4lite_slice_if.sv
// AXI4-Lite bundle shared by the rggen bridge and the pipeline slice.
interface rggen_axi4lite_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/rggen_axi4lite_slice.sv
// Registered AXI4-Lite pipeline stage: one two-entry skid buffer per channel,
// request and response directions independently bypassable.
module rggen_axi4lite_slice_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);
    // Bit 0 is main_valid, bit 1 is skid_valid, so both handshake outputs come
    // straight from flops.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e           state_q;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;
    logic             accept_in;
    logic             accept_out;

    assign in_ready_o  = ~state_q[1];
    assign out_valid_o = state_q[0];
    assign out_data_o  = main_q;
    assign accept_in   = in_valid_i & in_ready_o;
    assign accept_out  = out_valid_o & out_ready_i;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept_in) begin
                        state_q <= StBusy;
                        main_q  <= in_data_i;
                    end
                end
                StBusy: begin
                    if (accept_in && !accept_out) begin
                        state_q <= StFull;
                        skid_q  <= in_data_i;
                    end else if (accept_in) begin
                        main_q <= in_data_i;
                    end else if (accept_out) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (accept_out) begin
                        state_q <= StBusy;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end
endmodule

module rggen_axi4lite_slice #(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter bit          REQUEST_SLICE  = 1'b1,
    parameter bit          RESPONSE_SLICE = 1'b1
) (
    input logic            i_clk,
    input logic            i_rst_n,
    rggen_axi4lite_if.slave  slave_if,
    rggen_axi4lite_if.master master_if
);
    localparam int unsigned StrbWidth = BUS_WIDTH / 8;
    localparam int unsigned AwWidth   = ADDRESS_WIDTH + 3;
    localparam int unsigned WWidth    = BUS_WIDTH + StrbWidth;
    localparam int unsigned RWidth    = BUS_WIDTH + 2;

    if (REQUEST_SLICE) begin : g_request_slice
        logic [AwWidth-1:0] aw_out;
        logic [WWidth-1:0]  w_out;
        logic [AwWidth-1:0] ar_out;

        rggen_axi4lite_slice_skid #(.Width(AwWidth)) u_aw_skid (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .in_valid_i  (slave_if.awvalid),
            .in_ready_o  (slave_if.awready),
            .in_data_i   ({slave_if.awaddr, slave_if.awprot}),
            .out_valid_o (master_if.awvalid),
            .out_ready_i (master_if.awready),
            .out_data_o  (aw_out)
        );

        rggen_axi4lite_slice_skid #(.Width(WWidth)) u_w_skid (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .in_valid_i  (slave_if.wvalid),
            .in_ready_o  (slave_if.wready),
            .in_data_i   ({slave_if.wdata, slave_if.wstrb}),
            .out_valid_o (master_if.wvalid),
            .out_ready_i (master_if.wready),
            .out_data_o  (w_out)
        );

        rggen_axi4lite_slice_skid #(.Width(AwWidth)) u_ar_skid (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .in_valid_i  (slave_if.arvalid),
            .in_ready_o  (slave_if.arready),
            .in_data_i   ({slave_if.araddr, slave_if.arprot}),
            .out_valid_o (master_if.arvalid),
            .out_ready_i (master_if.arready),
            .out_data_o  (ar_out)
        );

        assign {master_if.awaddr, master_if.awprot} = aw_out;
        assign {master_if.wdata, master_if.wstrb}   = w_out;
        assign {master_if.araddr, master_if.arprot} = ar_out;
    end else begin : g_request_pass
        assign master_if.awvalid = slave_if.awvalid;
        assign master_if.awaddr  = slave_if.awaddr;
        assign master_if.awprot  = slave_if.awprot;
        assign slave_if.awready  = master_if.awready;
        assign master_if.wvalid  = slave_if.wvalid;
        assign master_if.wdata   = slave_if.wdata;
        assign master_if.wstrb   = slave_if.wstrb;
        assign slave_if.wready   = master_if.wready;
        assign master_if.arvalid = slave_if.arvalid;
        assign master_if.araddr  = slave_if.araddr;
        assign master_if.arprot  = slave_if.arprot;
        assign slave_if.arready  = master_if.arready;
    end

    if (RESPONSE_SLICE) begin : g_response_slice
        logic [RWidth-1:0] r_out;

        rggen_axi4lite_slice_skid #(.Width(2)) u_b_skid (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .in_valid_i  (master_if.bvalid),
            .in_ready_o  (master_if.bready),
            .in_data_i   (master_if.bresp),
            .out_valid_o (slave_if.bvalid),
            .out_ready_i (slave_if.bready),
            .out_data_o  (slave_if.bresp)
        );

        rggen_axi4lite_slice_skid #(.Width(RWidth)) u_r_skid (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .in_valid_i  (master_if.rvalid),
            .in_ready_o  (master_if.rready),
            .in_data_i   ({master_if.rdata, master_if.rresp}),
            .out_valid_o (slave_if.rvalid),
            .out_ready_i (slave_if.rready),
            .out_data_o  (r_out)
        );

        assign {slave_if.rdata, slave_if.rresp} = r_out;
    end else begin : g_response_pass
        assign slave_if.bvalid  = master_if.bvalid;
        assign slave_if.bresp   = master_if.bresp;
        assign master_if.bready = slave_if.bready;
        assign slave_if.rvalid  = master_if.rvalid;
        assign slave_if.rdata   = master_if.rdata;
        assign slave_if.rresp   = master_if.rresp;
        assign master_if.rready = slave_if.rready;
    end
endmodule
